// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: 2-flop synchroniser, per-channel stability counter,
// press/release pulses; long-press pulse enabled by `define DEBOUNCE_LONG_PRESS_EN.
module debounce_bank #(
  parameter int N            = 4,
  parameter int STABLE_TICKS = 50,
  parameter int PRESCALE     = 1,
  parameter int LONG_TICKS   = 1000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] iSWITCH,
  output logic [N-1:0] oSWITCH,
  output logic [N-1:0] oRISE,
  output logic [N-1:0] oFALL,
  output logic [N-1:0] oLONG
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_RELOAD = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  if (N < 1 || STABLE_TICKS < 1 || PRESCALE < 1 || LONG_TICKS < 1) begin : g_bad_params
    $error("debounce_bank: every parameter must be >= 1");
  end

  logic [PW-1:0]        pre_q, pre_d;
  logic                 tick;
  logic [N-1:0]         sync_meta_q, sync_meta_d;
  logic [N-1:0]         sync_q, sync_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]         sw_q, sw_d;
  logic [N-1:0]         rise_q, rise_d;
  logic [N-1:0]         fall_q, fall_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tick        = (pre_q == '0);
    pre_d       = tick ? PRE_RELOAD : pre_q - PW'(1);
    sync_meta_d = iSWITCH;
    sync_d      = sync_meta_q;
    sw_d        = sw_q;
    rise_d      = '0;
    fall_d      = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == sw_q[i]) begin
        // Any cycle of agreement restarts the count, tick or not.
        cnt_d[i] = '0;
      end else if (tick && cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = '0;
        sw_d[i]   = sync_q[i];
        rise_d[i] = sync_q[i];
        fall_d[i] = ~sync_q[i];
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q       <= PRE_RELOAD;
      sync_meta_q <= '0;
      sync_q      <= '0;
      cnt_q       <= '0;
      sw_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
    end else begin
      pre_q       <= pre_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      sw_q        <= sw_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign oSWITCH = sw_q;
  assign oRISE   = rise_q;
  assign oFALL   = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [N-1:0][HW-1:0] hold_q, hold_d;
  logic [N-1:0]         long_q, long_d;

  always_comb begin
    long_d = '0;
    for (int i = 0; i < N; i++) begin
      hold_d[i] = hold_q[i];
      if (!sw_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] != HOLD_MAX) begin
        // Saturation at HOLD_MAX makes the pulse fire once per press.
        hold_d[i] = hold_q[i] + HW'(1);
        long_d[i] = (hold_d[i] == HOLD_MAX);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign oLONG = long_q;
`else
  assign oLONG = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (PRESCALE=1 instance plus a PRESCALE=3 instance).
module tb_debounce_bank;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int EXP_LONG_CNT = 1;
  localparam int EXP_LONG_AT  = 10;
`else
  localparam int EXP_LONG_CNT = 0;
  localparam int EXP_LONG_AT  = -1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw, osw, orise, ofall, olong;
  logic [3:0] sw_p, osw_p, orise_p, ofall_p, olong_p;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  debounce_bank #(.N(4), .STABLE_TICKS(4), .PRESCALE(1), .LONG_TICKS(10)) u_dut (
    .CLK(clk), .RST(rst), .iSWITCH(sw),
    .oSWITCH(osw), .oRISE(orise), .oFALL(ofall), .oLONG(olong)
  );

  debounce_bank #(.N(4), .STABLE_TICKS(4), .PRESCALE(3), .LONG_TICKS(10)) u_pre (
    .CLK(clk), .RST(rst), .iSWITCH(sw_p),
    .oSWITCH(osw_p), .oRISE(orise_p), .oFALL(ofall_p), .oLONG(olong_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Watches oLONG over 30 cycles starting one cycle after an oRISE on ch0.
  task automatic long_window(input string tag);
    int cnt = 0;
    int at  = -1;
    logic [3:0] other = '0;
    for (int i = 1; i <= 30; i++) begin
      if (olong[0]) begin
        cnt++;
        at = i;
      end
      other |= olong & 4'b1110;
      cycles(1);
    end
    check({tag, "_count"}, cnt, EXP_LONG_CNT);
    check({tag, "_tick"}, at, EXP_LONG_AT);
    check({tag, "_others"}, other, 4'b0000);
  endtask

  initial begin
    int activity;
    int lat;
    logic rise_seen;

    rst  = 1'b0;
    sw   = '0;
    sw_p = '0;
    #1 rst = 1'b1;
    #1;
    check("reset_osw", osw, 4'b0000);
    check("reset_rise", orise, 4'b0000);
    check("reset_fall", ofall, 4'b0000);
    check("reset_long", olong, 4'b0000);
    check("reset_pre", {osw_p, orise_p, ofall_p, olong_p}, 16'h0000);
    @(negedge clk) rst = 1'b0;
    cycles(2);

    // Clean press on ch0, then long-press window
    sw[0] = 1'b1;
    cycles(5);
    check("press_early", osw, 4'b0000);
    cycles(1);
    check("press_osw", osw, 4'b0001);
    check("press_rise", orise, 4'b0001);
    check("press_fall", ofall, 4'b0000);
    cycles(1);
    check("press_rise_width", orise, 4'b0000);
    long_window("long1");

    // Release and re-press re-arms the long-press pulse
    sw[0] = 1'b0;
    cycles(6);
    check("release_fall", ofall, 4'b0001);
    check("release_osw", osw, 4'b0000);
    sw[0] = 1'b1;
    cycles(6);
    check("repress_rise", orise, 4'b0001);
    cycles(1);
    long_window("long2");

    // Bounce on ch1: toggle every 2 cycles for 20 cycles, then hold high
    activity = 0;
    for (int k = 0; k < 10; k++) begin
      sw[1] = (k % 2 == 0);
      repeat (2) begin
        cycles(1);
        if (osw[1] || orise[1] || ofall[1]) activity++;
      end
    end
    sw[1] = 1'b1;
    repeat (5) begin
      cycles(1);
      if (osw[1] || orise[1] || ofall[1]) activity++;
    end
    check("bounce_quiet", activity, 0);
    cycles(1);
    check("bounce_rise", orise, 4'b0010);
    check("bounce_osw", osw, 4'b0011);
    cycles(1);
    check("bounce_rise_width", orise, 4'b0000);

    // Simultaneous press on ch2/ch3, then release all four together
    sw[3:2] = 2'b11;
    cycles(6);
    check("multi_rise", orise, 4'b1100);
    check("multi_osw", osw, 4'b1111);
    sw = 4'b0000;
    cycles(5);
    check("multi_fall_early", ofall, 4'b0000);
    cycles(1);
    check("multi_fall", ofall, 4'b1111);
    check("multi_fall_rise", orise, 4'b0000);
    check("multi_fall_osw", osw, 4'b0000);
    cycles(1);
    check("multi_fall_width", ofall, 4'b0000);

    // Repeat the release but reset mid-count
    sw = 4'b1111;
    cycles(6);
    check("repress_all", osw, 4'b1111);
    sw = 4'b0000;
    cycles(2);
    check("midcount_osw", osw, 4'b1111);
    rst = 1'b1;
    #1;
    check("midreset_osw", osw, 4'b0000);
    check("midreset_pulses", {orise, ofall}, 8'h00);
    cycles(2);
    rst = 1'b0;
    activity = 0;
    repeat (10) begin
      cycles(1);
      if (|orise || |ofall || |osw) activity++;
    end
    check("post_reset_quiet", activity, 0);

    // Input held high through reset rises with normal latency
    sw[3] = 1'b1;
    rst   = 1'b1;
    cycles(2);
    check("held_in_reset", osw, 4'b0000);
    rst = 1'b0;
    cycles(5);
    check("held_early", osw, 4'b0000);
    cycles(1);
    check("held_osw", osw, 4'b1000);
    check("held_rise", orise, 4'b1000);

    // Prescaled instance: press on ch2 lands within 12..14 edges
    sw_p[2]   = 1'b1;
    lat       = 0;
    rise_seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cycles(1);
      if (lat == 0 && osw_p[2]) begin
        lat       = n;
        rise_seen = orise_p[2];
      end
    end
    check("pre_lat_ge12", (lat >= 12), 1);
    check("pre_lat_le14", (lat <= 14), 1);
    check("pre_rise", rise_seen, 1'b1);

    // 9-cycle pulse on ch3 is too short at PRESCALE=3
    activity = 0;
    sw_p[3] = 1'b1;
    repeat (9) begin
      cycles(1);
      if (osw_p[3] || orise_p[3]) activity++;
    end
    sw_p[3] = 1'b0;
    repeat (20) begin
      cycles(1);
      if (osw_p[3] || orise_p[3] || ofall_p[3]) activity++;
    end
    check("pre_glitch_rejected", activity, 0);
    check("pre_final_osw", osw_p, 4'b0100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
